// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared opcodes, state encoding, alu_op codes and stat bit indices for the SISC sequencer
package sisc_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_ALU_RR  = 4'h1;
  localparam logic [3:0] OP_ALU_IMM = 4'h2;
  localparam logic [3:0] OP_BRA     = 4'h3;
  localparam logic [3:0] OP_BRR     = 4'h4;
  localparam logic [3:0] OP_BNE     = 4'h5;
  localparam logic [3:0] OP_BNR     = 4'h6;
  localparam logic [3:0] OP_LOD     = 4'h8;
  localparam logic [3:0] OP_STR     = 4'h9;
  localparam logic [3:0] OP_HLT     = 4'hF;

  localparam logic [1:0] ALU_RR   = 2'b00;
  localparam logic [1:0] ALU_IMM  = 2'b01;
  localparam logic [1:0] ALU_ADDR = 2'b10;

  // stat = {C,V,N,Z}
  localparam int STAT_Z = 0;
  localparam int STAT_N = 1;
  localparam int STAT_V = 2;
  localparam int STAT_C = 3;

  typedef enum logic [2:0] {
    ST_START,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_NOP, OP_ALU_RR, OP_ALU_IMM, OP_BRA, OP_BRR, OP_BNE, OP_BNR,
      OP_LOD, OP_STR, OP_HLT: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sisc_br_cond.sv
// rtl/sisc_br_cond.sv - combinational branch taken/not-taken decision
// Ports:
//   opcode  in  4  current instruction opcode
//   mm      in  4  branch mask, aligned with stat
//   stat    in  4  status flags {C,V,N,Z}
//   taken   out 1  branch is taken (0 for non-branch opcodes)
module sisc_br_cond
  import sisc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  output logic       taken
);

  logic hit;

  // Any flag selected by the mask is set.
  assign hit = (mm[STAT_C] & stat[STAT_C]) | (mm[STAT_V] & stat[STAT_V]) |
               (mm[STAT_N] & stat[STAT_N]) | (mm[STAT_Z] & stat[STAT_Z]);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BRA, OP_BRR: taken = (mm == 4'h0) | hit;
      OP_BNE, OP_BNR: taken = ~hit;
      default:        taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sisc_mc_ctrl.sv
// rtl/sisc_mc_ctrl.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the SISC datapath
// Optional build macro: SISC_ILLEGAL_TRAP_EN (adds the illegal output; undefined opcodes halt).
// Ports:
//   clk, rst_f                      clock, asynchronous active-low reset
//   opcode, mm, stat                IR[31:28], IR[27:24], status {C,V,N,Z}
//   imem_ready, dmem_ready          memory handshakes
//   pc_rst, pc_write, pc_sel, br_sel  PC control
//   ir_load, imem_req               instruction fetch
//   dmem_req, dmem_we               data memory access
//   rf_we, wb_sel, rb_sel           register file control
//   alu_op, stat_en                 ALU function select, status update
//   halted (, illegal)              halt indication
module sisc_mc_ctrl
  import sisc_pkg::*;
#(
  parameter int RESET_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_f,
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  input  logic       imem_ready,
  input  logic       dmem_ready,
`ifdef SISC_ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output logic       pc_rst,
  output logic       pc_write,
  output logic       pc_sel,
  output logic       br_sel,
  output logic       ir_load,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       rf_we,
  output logic       wb_sel,
  output logic       rb_sel,
  output logic [1:0] alu_op,
  output logic       stat_en,
  output logic       halted
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

  state_t     state, state_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic       br_taken;

  sisc_br_cond u_br_cond (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat),
    .taken  (br_taken)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state    <= ST_START;
      hold_cnt <= 4'h0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

`ifdef SISC_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky until reset: HALT is only left through reset anyway.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      illegal_q <= 1'b0;
    end else if (state == ST_DECODE && !op_legal(opcode)) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`endif

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    pc_rst    = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    br_sel    = 1'b0;
    ir_load   = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 1'b0;
    rb_sel    = 1'b0;
    alu_op    = ALU_RR;
    stat_en   = 1'b0;
    halted    = 1'b0;

    case (state)
      ST_START: begin
        pc_rst = 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_FETCH;
        end else begin
          hold_nxt = hold_cnt + 4'h1;
        end
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load   = 1'b1;
          pc_write  = 1'b1;
          state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (opcode)
          OP_BRA, OP_BRR, OP_BNE, OP_BNR: begin
            if (br_taken) begin
              pc_write = 1'b1;
              pc_sel   = 1'b1;
              br_sel   = (opcode == OP_BRR) || (opcode == OP_BNR);
            end
            state_nxt = ST_FETCH;
          end
          OP_HLT:                                 state_nxt = ST_HALT;
          OP_ALU_RR, OP_ALU_IMM, OP_LOD, OP_STR:  state_nxt = ST_EXECUTE;
          default: begin
            state_nxt = ST_FETCH;
`ifdef SISC_ILLEGAL_TRAP_EN
            if (!op_legal(opcode)) state_nxt = ST_HALT;
`endif
          end
        endcase
      end

      ST_EXECUTE: begin
        case (opcode)
          OP_ALU_RR: begin
            alu_op    = ALU_RR;
            stat_en   = 1'b1;
            state_nxt = ST_WRITEBACK;
          end
          OP_ALU_IMM: begin
            alu_op    = ALU_IMM;
            stat_en   = 1'b1;
            state_nxt = ST_WRITEBACK;
          end
          OP_LOD: begin
            alu_op    = ALU_ADDR;
            state_nxt = ST_MEM;
          end
          OP_STR: begin
            alu_op    = ALU_ADDR;
            rb_sel    = 1'b1;
            state_nxt = ST_MEM;
          end
          default: state_nxt = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        alu_op   = ALU_ADDR;
        dmem_we  = (opcode == OP_STR);
        rb_sel   = (opcode == OP_STR);
        if (dmem_ready) begin
          state_nxt = (opcode == OP_STR) ? ST_FETCH : ST_WRITEBACK;
        end
      end

      ST_WRITEBACK: begin
        rf_we  = 1'b1;
        wb_sel = (opcode == OP_LOD);
        // Keep the ALU function stable so the write data does not glitch.
        case (opcode)
          OP_ALU_IMM: alu_op = ALU_IMM;
          OP_LOD:     alu_op = ALU_ADDR;
          default:    alu_op = ALU_RR;
        endcase
        state_nxt = ST_FETCH;
      end

      ST_HALT: halted = 1'b1;

      default: state_nxt = ST_START;
    endcase
  end

endmodule
